// File: rtl/prediv_prog.sv
// prediv_prog: two-stage programmable prescaler.
//   Stage 1 counts 0..tc and pulses tick at the wrap. Stage 2 counts ticks
//   0..DIV2 and pulses tick2 together with the tick that wraps it.
//   A new stage-1 terminal count written while counting is staged in tc_nxt
//   and takes effect at the next wrap, so a period is never cut short or
//   overrun. A write while disabled takes effect at once and restarts stage 1.
//
// Ports:
//   clk      in            clock, rising edge
//   rst      in            asynchronous reset, active low
//   en       in            count enable; low freezes both stages
//   div_wr   in            strobe: request new stage-1 terminal count
//   div_in   in  [WIDTH]   new terminal count, sampled with div_wr
//   tick     out           stage-1 wrap pulse (combinational)
//   tick2    out           stage-2 wrap pulse, coincident with tick
//   pending  out           staged terminal count waiting for next wrap
//   cnt      out [WIDTH]   current stage-1 count
//   sqw      out           (PREDIV_SQW_EN only) toggles on every tick
//
// Build option: define PREDIV_SQW_EN to add the sqw output and its register.
module prediv_prog #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DIV_RST = 39999,
  parameter int unsigned DIV2    = 999,
  parameter int unsigned W2      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             tick2,
  output logic             pending,
  output logic [WIDTH-1:0] cnt
`ifdef PREDIV_SQW_EN
  ,
  output logic             sqw
`endif
);

  if (DIV2 > (2 ** W2) - 1) begin : g_div2_check
    $error("prediv_prog: DIV2 does not fit in W2 bits");
  end

  logic [WIDTH-1:0] tc;
  logic [WIDTH-1:0] tc_nxt;
  logic [W2-1:0]    cnt2;
  logic             wrap;
  logic             wrap2;

  // Gated by rst so a zero DIV_RST cannot pulse tick while held in reset.
  assign wrap  = rst & en & (cnt == tc);
  assign wrap2 = wrap & (cnt2 == W2'(DIV2));
  assign tick  = wrap;
  assign tick2 = wrap2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      cnt2    <= '0;
      tc      <= WIDTH'(DIV_RST);
      tc_nxt  <= WIDTH'(DIV_RST);
      pending <= 1'b0;
    end else if (!en) begin
      // Disabled write: nothing is mid-period, so apply immediately.
      if (div_wr) begin
        tc      <= div_in;
        cnt     <= '0;
        pending <= 1'b0;
      end
    end else if (wrap) begin
      cnt  <= '0;
      cnt2 <= wrap2 ? '0 : cnt2 + W2'(1);
      // A write landing on the wrap itself beats any older staged value.
      if (div_wr) begin
        tc      <= div_in;
        pending <= 1'b0;
      end else if (pending) begin
        tc      <= tc_nxt;
        pending <= 1'b0;
      end
    end else begin
      cnt <= cnt + WIDTH'(1);
      if (div_wr) begin
        tc_nxt  <= div_in;
        pending <= 1'b1;
      end
    end
  end

`ifdef PREDIV_SQW_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sqw <= 1'b0;
    end else if (wrap) begin
      sqw <= ~sqw;
    end
  end
`endif

endmodule

// File: doc/prediv_prog.md
PREDIV_PROG -- requirements
Module: prediv_prog

Interface
REQ-001 Parameter WIDTH, default 16, width of the stage-1 counter and divisor.
REQ-002 Parameter DIV_RST, default 39999, stage-1 terminal count loaded at reset.
REQ-003 Parameter DIV2, default 999, stage-2 terminal count, fixed at elaboration.
REQ-004 Parameter W2, default 10, stage-2 counter width; DIV2 SHALL fit in W2 bits.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  count enable; low freezes both stages.
REQ-008 div_wr  in  1  one-cycle strobe; request new stage-1 terminal count.
REQ-009 div_in  in  WIDTH  new stage-1 terminal count, sampled when div_wr=1.
REQ-010 tick  out  1  one-cycle pulse at stage-1 wrap.
REQ-011 tick2  out  1  one-cycle pulse at stage-2 wrap, coincident with a tick.
REQ-012 pending  out  1  staged divisor waiting for next stage-1 wrap.
REQ-013 cnt  out  WIDTH  current stage-1 count.

Function
REQ-014 Registers: cnt, tc (active terminal count), tc_nxt (staged), pending, cnt2 (W2 bits).
REQ-015 en=1, cnt!=tc: cnt<=cnt+1; tick=0.
REQ-016 en=1, cnt==tc: cnt<=0; tick=1 combinationally that cycle; stage-1 period = tc+1 cycles.
REQ-017 tc=0: tick SHALL be high every enabled cycle, cnt stays 0.
REQ-018 en=0: cnt, cnt2 held; tick=0, tick2=0.
REQ-019 Stage 2: on each tick, cnt2<=0 if cnt2==DIV2 else cnt2+1; tick2=tick & (cnt2==DIV2).
REQ-020 div_wr with en=0: tc<=div_in, cnt<=0, cnt2 unchanged, pending<=0 next cycle.
REQ-021 div_wr with en=1, no wrap that cycle: tc_nxt<=div_in, pending<=1.
REQ-022 At a wrap with pending=1: tc<=tc_nxt, pending<=0; new period starts at cnt=0.
REQ-023 div_wr coincident with a wrap: div_in loaded directly into tc at that wrap, pending stays 0.
REQ-024 div_wr while pending=1: tc_nxt overwritten with latest div_in; last write wins.
REQ-025 cnt>tc impossible by construction; tc only changes when cnt is cleared.
REQ-026 Counter arithmetic modulo 2^WIDTH; no overflow beyond tc since wrap precedes it.

Reset
REQ-027 rst=0 asynchronously: cnt=0, cnt2=0, tc=DIV_RST, tc_nxt=DIV_RST, pending=0.
REQ-028 During reset tick=0, tick2=0; reset mid-period discards staged divisor.
REQ-029 First tick after release SHALL occur DIV_RST+1 enabled cycles after first enabled edge.

Configuration
REQ-030 Macro PREDIV_SQW_EN defined: output sqw (1 bit) added, toggles on every tick, reset 0, frozen when en=0.
REQ-031 PREDIV_SQW_EN undefined: no sqw port, no toggle register; all other behaviour identical.

Verification
REQ-032 Reset release, en=1, defaults -> tick at cycles 40000, 80000; tick2 at cycle 40,000,000 with tick.
REQ-033 en=1, div_wr div_in=4 at cnt=10 (tc=39999) -> pending=1, tick at cnt=39999, then ticks every 5 cycles, pending=0.
REQ-034 en=0, div_wr div_in=2 -> tc=2, cnt=0 next cycle; en=1 -> tick every 3 cycles.
REQ-035 div_in=0 loaded -> tick continuously high while en=1; en toggled low -> tick low, cnt held.
REQ-036 Two div_wr (7 then 3) before wrap -> period after wrap is 4 cycles; rst=0 mid-period -> outputs cleared immediately, tc=39999.
REQ-037 PREDIV_SQW_EN build, tc=4 -> sqw period 10 cycles, 50% duty; non-define build compiles without sqw.
